// File: rtl/rgb_to_hsv_engine.sv
// rgb_to_hsv_engine
//   Frame-sequential RGB->HSV converter. Each pixel is fetched from the source
//   region of a shared SRAM, converted with one shared bit-serial restoring
//   divider (saturation first, then hue), and written packed to the
//   destination region.
//
//   State table
//     state   | meaning
//     --------+------------------------------------------------------------
//     IDLE    | waiting for enable; counter cleared
//     FETCH   | source address on the bus, read data arrives next cycle
//     LOAD    | sample R/G/B, find max/min/delta, start saturation divide
//     DIV_S   | DW cycles of saturation divide (delta<<FracBits)/max
//     DIV_H   | DW cycles of hue divide (|x-y|<<FracBits)/delta
//     WRITE   | destination address + packed HSV on the bus, wren high
//     DONE    | frame complete, done held until enable drops
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active high
//   enable     level: high runs/holds the frame, low aborts and clears
//   pause      high freezes every register (bus arbitration stall)
//   data_read  SRAM read data, valid one cycle after address
//   address    SRAM word address (mod 2^18)
//   wren       write strobe, one cycle per pixel
//   data_write {H, 8'h00, S, V} & StoreMask
//   done       frame complete
module rgb_to_hsv_engine #(
  parameter int          ImageWidth  = 320,
  parameter int          ImageHeight = 240,
  parameter int          SrcOffset   = 76801,
  parameter int          DstOffset   = 153602,
  parameter int          RLane       = 0,
  parameter int          GLane       = 1,
  parameter int          BLane       = 3,
  parameter int          FracBits    = 8,
  parameter int          HueShift    = 3,
  parameter logic [7:0]  NoHue       = 8'hFF,
  parameter logic [31:0] StoreMask   = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pause,
  input  logic [31:0] data_read,
  output logic [17:0] address,
  output logic        wren,
  output logic [31:0] data_write,
  output logic        done
);

  localparam int DW = 8 + FracBits;
  localparam int CW = $clog2(DW);
  localparam int RW = DW + 3;
  localparam logic [17:0] SRC_BASE = 18'(SrcOffset);
  localparam logic [17:0] DST_BASE = 18'(DstOffset);
  localparam logic [17:0] LAST_PIX = 18'(ImageWidth * ImageHeight - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DIV_S, S_DIV_H, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_nx;
  logic [17:0]     cnt_q, cnt_nx;
  logic [17:0]     addr_q, addr_nx;
  logic            wren_q, wren_nx;
  logic [31:0]     wdata_q, wdata_nx;
  logic            done_q, done_nx;
  logic [7:0]      v_q, v_nx;
  logic [7:0]      s_q, s_nx;
  logic [7:0]      delta_q, delta_nx;
  logic [7:0]      hdiff_q, hdiff_nx;
  logic            hneg_q, hneg_nx;
  logic [1:0]      maxsel_q, maxsel_nx;
  logic [DW:0]     rem_q, rem_nx;
  logic [DW-1:0]   num_q, num_nx;
  logic [7:0]      den_q, den_nx;
  logic [DW-1:0]   quo_q, quo_nx;
  logic [CW-1:0]   bit_q, bit_nx;

  // Pixel decode from the configured byte lanes.
  logic [7:0] pix_r, pix_g, pix_b;
  logic [7:0] px_max, px_min, px_delta, px_x, px_y, px_hdiff;
  logic [1:0] px_sel;
  logic       px_hneg;

  assign pix_r = data_read[RLane*8 +: 8];
  assign pix_g = data_read[GLane*8 +: 8];
  assign pix_b = data_read[BLane*8 +: 8];

  // The spare lane is intentionally ignored.
  logic unused_lanes;
  assign unused_lanes = ^data_read;

  always_comb begin
    px_sel = 2'd0;
    px_max = pix_r;
    px_x   = pix_g;
    px_y   = pix_b;
    // Ties resolve R over G over B.
    if (pix_r >= pix_g && pix_r >= pix_b) begin
      px_sel = 2'd0; px_max = pix_r; px_x = pix_g; px_y = pix_b;
    end else if (pix_g >= pix_b) begin
      px_sel = 2'd1; px_max = pix_g; px_x = pix_b; px_y = pix_r;
    end else begin
      px_sel = 2'd2; px_max = pix_b; px_x = pix_r; px_y = pix_g;
    end
    px_min = pix_r;
    if (pix_g < px_min) px_min = pix_g;
    if (pix_b < px_min) px_min = pix_b;
    px_delta = px_max - px_min;
    px_hneg  = (px_x < px_y);
    px_hdiff = px_hneg ? (px_y - px_x) : (px_x - px_y);
  end

  // One restoring divider step: shift in the next numerator bit and subtract
  // the denominator if it fits. The extra remainder bit is the guard bit.
  logic [DW:0]   div_shift, div_rem;
  logic [DW-1:0] div_quo;
  logic          div_fits;

  always_comb begin
    div_shift = (rem_q << 1) | (DW+1)'(num_q[DW-1]);
    div_fits  = (div_shift >= (DW+1)'(den_q));
    div_rem   = div_fits ? (div_shift - (DW+1)'(den_q)) : div_shift;
    div_quo   = {quo_q[DW-2:0], div_fits};
  end

  // Saturation from the completed quotient, clamped to 8 bits
  // (delta==max yields 1.0, which would otherwise wrap).
  logic [DW-1:0] sat_q;
  logic [7:0]    sat_code;

  always_comb begin
    sat_q    = div_quo >> (FracBits - 8);
    sat_code = (sat_q > DW'(255)) ? 8'hFF : sat_q[7:0];
  end

  // Hue sector arithmetic: base + q when x>=y, otherwise base' - q.
  logic [RW-1:0] hue_pos, hue_neg, hue_raw;
  logic [7:0]    hue_code;

  always_comb begin
    case (maxsel_q)
      2'd1: begin
        hue_pos = RW'(2) << FracBits;
        hue_neg = RW'(2) << FracBits;
      end
      2'd2: begin
        hue_pos = RW'(4) << FracBits;
        hue_neg = RW'(4) << FracBits;
      end
      default: begin
        hue_pos = '0;
        hue_neg = RW'(6) << FracBits;
      end
    endcase
    hue_raw  = hneg_q ? (hue_neg - RW'(div_quo)) : (hue_pos + RW'(div_quo));
    hue_code = 8'(hue_raw >> HueShift);
  end

  function automatic logic [31:0] pack_hsv(input logic [7:0] h, input logic [7:0] s,
                                           input logic [7:0] v);
    return {h, 8'h00, s, v} & StoreMask;
  endfunction

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    addr_nx   = addr_q;
    wren_nx   = wren_q;
    wdata_nx  = wdata_q;
    done_nx   = done_q;
    v_nx      = v_q;
    s_nx      = s_q;
    delta_nx  = delta_q;
    hdiff_nx  = hdiff_q;
    hneg_nx   = hneg_q;
    maxsel_nx = maxsel_q;
    rem_nx    = rem_q;
    num_nx    = num_q;
    den_nx    = den_q;
    quo_nx    = quo_q;
    bit_nx    = bit_q;

    if (!enable) begin
      // Abort wins over pause.
      state_nx = S_IDLE;
      cnt_nx   = '0;
      addr_nx  = '0;
      wren_nx  = 1'b0;
      wdata_nx = '0;
      done_nx  = 1'b0;
    end else if (!pause) begin
      case (state_q)
        S_IDLE: begin
          if (!done_q) begin
            state_nx = S_FETCH;
            addr_nx  = SRC_BASE + cnt_q;
            wren_nx  = 1'b0;
          end
        end
        S_FETCH: state_nx = S_LOAD;
        S_LOAD: begin
          v_nx      = px_max;
          delta_nx  = px_delta;
          hdiff_nx  = px_hdiff;
          hneg_nx   = px_hneg;
          maxsel_nx = px_sel;
          if (px_max == 8'd0 || px_delta == 8'd0) begin
            // Grey or black: hue undefined, no divide needed.
            state_nx = S_WRITE;
            wren_nx  = 1'b1;
            addr_nx  = DST_BASE + cnt_q;
            wdata_nx = pack_hsv(NoHue, 8'h00, px_max);
          end else begin
            state_nx = S_DIV_S;
            rem_nx   = '0;
            num_nx   = {px_delta, {FracBits{1'b0}}};
            den_nx   = px_max;
            quo_nx   = '0;
            bit_nx   = CW'(DW - 1);
          end
        end
        S_DIV_S: begin
          rem_nx = div_rem;
          num_nx = num_q << 1;
          quo_nx = div_quo;
          bit_nx = bit_q - CW'(1);
          if (bit_q == '0) begin
            s_nx     = sat_code;
            state_nx = S_DIV_H;
            rem_nx   = '0;
            num_nx   = {hdiff_q, {FracBits{1'b0}}};
            den_nx   = delta_q;
            quo_nx   = '0;
            bit_nx   = CW'(DW - 1);
          end
        end
        S_DIV_H: begin
          rem_nx = div_rem;
          num_nx = num_q << 1;
          quo_nx = div_quo;
          bit_nx = bit_q - CW'(1);
          if (bit_q == '0) begin
            state_nx = S_WRITE;
            wren_nx  = 1'b1;
            addr_nx  = DST_BASE + cnt_q;
            wdata_nx = pack_hsv(hue_code, s_q, v_q);
          end
        end
        S_WRITE: begin
          cnt_nx  = cnt_q + 18'd1;
          wren_nx = 1'b0;
          if (cnt_q == LAST_PIX) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_FETCH;
            addr_nx  = SRC_BASE + cnt_q + 18'd1;
          end
        end
        S_DONE: wren_nx = 1'b0;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      v_q      <= '0;
      s_q      <= '0;
      delta_q  <= '0;
      hdiff_q  <= '0;
      hneg_q   <= 1'b0;
      maxsel_q <= '0;
      rem_q    <= '0;
      num_q    <= '0;
      den_q    <= '0;
      quo_q    <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      addr_q   <= addr_nx;
      wren_q   <= wren_nx;
      wdata_q  <= wdata_nx;
      done_q   <= done_nx;
      v_q      <= v_nx;
      s_q      <= s_nx;
      delta_q  <= delta_nx;
      hdiff_q  <= hdiff_nx;
      hneg_q   <= hneg_nx;
      maxsel_q <= maxsel_nx;
      rem_q    <= rem_nx;
      num_q    <= num_nx;
      den_q    <= den_nx;
      quo_q    <= quo_nx;
      bit_q    <= bit_nx;
    end
  end

  assign address    = addr_q;
  assign wren       = wren_q;
  assign data_write = wdata_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rgb_to_hsv_engine.sv
// tb_rgb_to_hsv_engine
//   Bench for rgb_to_hsv_engine on a 4x2 frame. A synchronous SRAM model feeds
//   pixels; an integer HSV model predicts every written word and its latency.
module tb_rgb_to_hsv_engine;

  localparam int          NPIX = 8;
  localparam logic [17:0] SRC  = 18'd76801;
  localparam logic [17:0] DST  = 18'd153602;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic [31:0] data_read = 32'h0;
  logic [17:0] address;
  logic        wren;
  logic [31:0] data_write;
  logic        done;

  int errors = 0;
  int checks = 0;

  int          img_r [NPIX];
  int          img_g [NPIX];
  int          img_b [NPIX];
  logic [31:0] got_word [NPIX];
  int          got_lat [NPIX];

  rgb_to_hsv_engine #(
    .ImageWidth (4),
    .ImageHeight(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pause     (pause),
    .data_read (data_read),
    .address   (address),
    .wren      (wren),
    .data_write(data_write),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
    end
  endtask

  // HSV from the plain definition in integer arithmetic.
  function automatic logic [31:0] model_word(input int r, input int g, input int b);
    int mx, mn, d, s, raw, h;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    if (d == 0) return {8'hFF, 8'h00, 8'h00, 8'(mx)};
    s = (d * 256) / mx;
    if (s > 255) s = 255;
    if (r >= g && r >= b) begin
      raw = (g >= b) ? ((g - b) * 256) / d : 6 * 256 - ((b - g) * 256) / d;
    end else if (g >= b) begin
      raw = (b >= r) ? 2 * 256 + ((b - r) * 256) / d : 2 * 256 - ((r - b) * 256) / d;
    end else begin
      raw = (r >= g) ? 4 * 256 + ((r - g) * 256) / d : 4 * 256 - ((g - r) * 256) / d;
    end
    h = (raw / 8) % 256;
    return {8'(h), 8'h00, 8'(s), 8'(mx)};
  endfunction

  function automatic int model_lat(input int r, input int g, input int b);
    int mx, mn;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    return (mx == mn) ? 3 : 35;
  endfunction

  // Source pixels: R lane0, G lane1, junk lane2, B lane3.
  function automatic logic [31:0] sram_word(input logic [17:0] a);
    int k;
    k = int'(a) - int'(SRC);
    if (k >= 0 && k < NPIX) return {8'(img_b[k]), 8'hA5, 8'(img_g[k]), 8'(img_r[k])};
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) data_read <= sram_word(address);

  // Edge bookkeeping: which edges ran, which were frozen by pause.
  int cyc = 0;
  int frozen_cnt = 0;
  bit en_at_edge = 1'b0;
  bit frozen_last = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    en_at_edge  <= enable && !reset;
    frozen_last <= enable && pause && !reset;
    if (enable && pause && !reset) frozen_cnt <= frozen_cnt + 1;
  end

  // Compare process.
  int          widx = 0;
  bit          fetch_seen = 1'b0;
  int          fetch_cyc = 0, frozen_at_fetch = 0;
  int          last_wr_cyc = 0, frozen_at_wr = 0;
  logic [17:0] p_addr = 18'h0;
  logic        p_wren = 1'b0, p_done = 1'b0;
  logic [31:0] p_wdata = 32'h0;

  always @(negedge clk) begin
    if (reset || !en_at_edge) begin
      chk(address == 18'h0 && !wren && data_write == 32'h0 && !done, "cleared",
          $sformatf("addr=%0h wren=%0b data=%0h done=%0b", address, wren, data_write, done),
          "all zero");
      widx = 0;
      fetch_seen = 1'b0;
    end else if (frozen_last) begin
      chk(address == p_addr && wren == p_wren && data_write == p_wdata && done == p_done,
          "pause_hold",
          $sformatf("addr=%0h wren=%0b data=%0h done=%0b", address, wren, data_write, done),
          $sformatf("addr=%0h wren=%0b data=%0h done=%0b", p_addr, p_wren, p_wdata, p_done));
    end else begin
      if (wren) begin
        chk(!p_wren, "wren_pulse", "wren high two cycles", "single-cycle wren");
        if (!p_wren) begin
          chk(widx < NPIX, "write_count", $sformatf("write #%0d", widx), "at most 8 writes");
          if (widx < NPIX) begin
            chk(address == DST + 18'(widx), "wr_addr", $sformatf("%0h", address),
                $sformatf("%0h", DST + 18'(widx)));
            chk(data_write == model_word(img_r[widx], img_g[widx], img_b[widx]), "wr_data",
                $sformatf("%08h", data_write),
                $sformatf("%08h", model_word(img_r[widx], img_g[widx], img_b[widx])));
            chk(fetch_seen &&
                (cyc - fetch_cyc + 1 - (frozen_cnt - frozen_at_fetch)) ==
                model_lat(img_r[widx], img_g[widx], img_b[widx]), "wr_lat",
                $sformatf("%0d (fetch_seen=%0b)", cyc - fetch_cyc + 1 - (frozen_cnt - frozen_at_fetch),
                          fetch_seen),
                $sformatf("%0d", model_lat(img_r[widx], img_g[widx], img_b[widx])));
            got_word[widx] = data_write;
            got_lat[widx]  = cyc - fetch_cyc + 1;
            last_wr_cyc    = cyc;
            frozen_at_wr   = frozen_cnt;
            widx++;
            fetch_seen = 1'b0;
          end
        end
      end else if (!fetch_seen && widx < NPIX && address == SRC + 18'(widx)) begin
        fetch_seen      = 1'b1;
        fetch_cyc       = cyc;
        frozen_at_fetch = frozen_cnt;
      end
      if (p_done) begin
        chk(done, "done_hold", $sformatf("%0b", done), "1");
      end else if (done) begin
        chk(widx == NPIX && (cyc - last_wr_cyc - (frozen_cnt - frozen_at_wr)) == 1, "done_rise",
            $sformatf("writes=%0d gap=%0d", widx, cyc - last_wr_cyc - (frozen_cnt - frozen_at_wr)),
            "writes=8 gap=1");
      end
    end
    p_addr  = address;
    p_wren  = wren;
    p_wdata = data_write;
    p_done  = done;
  end

  task automatic set_pix(input int k, input int r, input int g, input int b);
    img_r[k] = r; img_g[k] = g; img_b[k] = b;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(done, "done_timeout", $sformatf("done=%0b after %0d cycles", done, n), "done=1");
  endtask

  task automatic wait_writes(input int target, input bit need_fetch, input int limit);
    int n;
    n = 0;
    while (!(widx == target && (fetch_seen || !need_fetch)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(widx == target, "progress_timeout", $sformatf("writes=%0d", widx),
        $sformatf("writes=%0d", target));
  endtask

  initial begin
    set_pix(0, 255, 0, 0);
    set_pix(1, 0, 255, 0);
    set_pix(2, 0, 0, 255);
    set_pix(3, 255, 0, 128);
    set_pix(4, 80, 80, 80);
    set_pix(5, 0, 0, 0);
    set_pix(6, 10, 200, 50);
    set_pix(7, 200, 100, 250);

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk(address == 18'h0 && !wren && data_write == 32'h0 && !done, "reset_state",
        $sformatf("addr=%0h wren=%0b data=%0h done=%0b", address, wren, data_write, done),
        "all zero");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: reference pixels.
    enable = 1'b1;
    wait_done(1000);
    repeat (6) @(negedge clk);
    chk(widx == NPIX, "frame1_writes", $sformatf("%0d", widx), "8");
    chk(got_word[0] == 32'h0000FFFF, "red",   $sformatf("%08h", got_word[0]), "0000ffff");
    chk(got_word[1] == 32'h4000FFFF, "green", $sformatf("%08h", got_word[1]), "4000ffff");
    chk(got_word[2] == 32'h8000FFFF, "blue",  $sformatf("%08h", got_word[2]), "8000ffff");
    chk(got_word[3] == 32'hB000FFFF, "rose",  $sformatf("%08h", got_word[3]), "b000ffff");
    chk(got_word[4] == 32'hFF000050, "grey",  $sformatf("%08h", got_word[4]), "ff000050");
    chk(got_word[5] == 32'hFF000000, "black", $sformatf("%08h", got_word[5]), "ff000000");
    chk(got_lat[0] == 35, "lat_chromatic", $sformatf("%0d", got_lat[0]), "35");
    chk(got_lat[4] == 3, "lat_grey", $sformatf("%0d", got_lat[4]), "3");
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 2: same image, 5-cycle pause inside the hue divide of pixel 3.
    enable = 1'b1;
    wait_writes(3, 1'b1, 500);
    repeat (22) @(negedge clk);
    pause = 1'b1;
    repeat (5) @(negedge clk);
    pause = 1'b0;
    wait_done(1000);
    chk(got_word[3] == 32'hB000FFFF, "pause_data", $sformatf("%08h", got_word[3]), "b000ffff");
    chk(got_lat[3] == 40, "pause_lat", $sformatf("%0d", got_lat[3]), "40");
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 3: ties and edge cases.
    set_pix(0, 255, 255, 0);
    set_pix(1, 0, 255, 255);
    set_pix(2, 255, 0, 255);
    set_pix(3, 1, 0, 0);
    set_pix(4, 100, 50, 25);
    set_pix(5, 17, 34, 51);
    set_pix(6, 255, 254, 253);
    set_pix(7, 128, 128, 127);
    enable = 1'b1;
    wait_done(1000);
    chk(got_word[0] == 32'h2000FFFF, "tie_rg", $sformatf("%08h", got_word[0]), "2000ffff");
    chk(got_word[1] == 32'h6000FFFF, "tie_gb", $sformatf("%08h", got_word[1]), "6000ffff");
    chk(got_word[2] == 32'hA000FFFF, "tie_rb", $sformatf("%08h", got_word[2]), "a000ffff");
    chk(got_word[3] == 32'h0000FF01, "dim_red", $sformatf("%08h", got_word[3]), "0000ff01");
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 4: abort mid-frame.
    enable = 1'b1;
    wait_writes(2, 1'b0, 500);
    enable = 1'b0;
    @(negedge clk);
    chk(!wren && !done && address == 18'h0, "abort",
        $sformatf("wren=%0b done=%0b addr=%0h", wren, done, address), "wren=0 done=0 addr=0");
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-divide.
    enable = 1'b1;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk(address == 18'h0 && !wren && data_write == 32'h0 && !done, "async_reset",
        $sformatf("addr=%0h wren=%0b data=%0h done=%0b", address, wren, data_write, done),
        "all zero");
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
